// File: rtl/rt_read_gather.sv
// rt_read_gather: gathers one real-time block of board registers into a quadlet stream.
// Define RT_READ_CHECKSUM_EN to append a two's-complement checksum quadlet.
module rt_read_gather #(
  parameter int NUM_MOTORS   = 4,
  parameter int NUM_ENCODERS = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] timestamp,
  output logic        rd_req,
  input  logic        rd_gnt,
  output logic [15:0] reg_raddr,
  input  logic [31:0] reg_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_index,
  output logic        out_last,
  output logic        busy
);
  localparam int N = 4 + 2 * NUM_MOTORS + 5 * NUM_ENCODERS;
`ifdef RT_READ_CHECKSUM_EN
  localparam logic [7:0] LAST = 8'(N);
`else
  localparam logic [7:0] LAST = 8'(N - 1);
`endif
  localparam logic [7:0] NEND = 8'(N);
  localparam logic [3:0] MCH  = 4'(NUM_MOTORS);
  localparam logic [3:0] ECH  = 4'(NUM_ENCODERS);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, CAPT, PUSH} state_t;
  state_t state, state_n;

  logic [7:0]  idx, nidx;
  logic [3:0]  ch, off, ch_n, off_n;
  logic [31:0] ts_q, data_q;
  logic        last_q, gnt_q, direct, accept, wrap;
`ifdef RT_READ_CHECKSUM_EN
  logic [31:0] sum;
  assign direct = (idx == 8'd1) || (idx == NEND);
`else
  assign direct = (idx == 8'd1);
`endif

  assign accept    = (state == PUSH) && out_ready;
  assign rd_req    = (state != IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == PUSH);
  assign out_data  = data_q;
  assign out_index = idx;
  assign out_last  = last_q;
  assign reg_raddr = {8'h00, ch, off};

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Leaving REQ waits on a registered grant so the arbiter sees rd_req first.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = REQ;
      REQ:  if (gnt_q) state_n = ADDR;
      ADDR: begin
        if (direct)      state_n = PUSH;
        else if (rd_gnt) state_n = CAPT;
      end
      CAPT: state_n = PUSH;
      PUSH: if (out_ready) state_n = (idx == LAST) ? IDLE : ADDR;
      default: state_n = IDLE;
    endcase
  end

  // Address walk: header, ADC, motor status, then encoder fields group-major.
  always_comb begin
    nidx  = idx + 8'd1;
    ch_n  = ch;
    off_n = off;
    wrap  = (off == 4'h0 || off == 4'hC) ? (ch == MCH) : (ch == ECH);
    if (nidx == 8'd2) begin
      ch_n  = 4'h0;
      off_n = 4'hA;
    end else if (nidx == 8'd3) begin
      off_n = 4'hB;
    end else if (nidx == 8'd4) begin
      ch_n  = 4'h1;
      off_n = 4'h0;
    end else if (nidx >= 8'd5 && nidx < NEND) begin
      if (wrap) begin
        ch_n = 4'h1;
        if (off == 4'h0)      off_n = 4'hC;
        else if (off == 4'hC) off_n = 4'h5;
        else                  off_n = off + 4'h1;
      end else begin
        ch_n = ch + 4'h1;
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      idx    <= 8'h00;
      ch     <= 4'h0;
      off    <= 4'h0;
      ts_q   <= 32'h0;
      data_q <= 32'h0;
      last_q <= 1'b0;
      gnt_q  <= 1'b0;
`ifdef RT_READ_CHECKSUM_EN
      sum    <= 32'h0;
`endif
    end else begin
      gnt_q <= rd_gnt;
      if (state == IDLE && start) begin
        idx  <= 8'h00;
        ch   <= 4'h0;
        off  <= 4'h0;
        ts_q <= timestamp;
`ifdef RT_READ_CHECKSUM_EN
        sum  <= 32'h0;
`endif
      end
      if (state == ADDR && direct) begin
`ifdef RT_READ_CHECKSUM_EN
        data_q <= (idx == 8'd1) ? ts_q : (~sum + 32'd1);
`else
        data_q <= ts_q;
`endif
        last_q <= (idx == LAST);
      end
      if (state == CAPT) begin
        data_q <= reg_rdata;
        last_q <= (idx == LAST);
      end
      if (accept && idx != LAST) begin
        idx <= nidx;
        ch  <= ch_n;
        off <= off_n;
      end
`ifdef RT_READ_CHECKSUM_EN
      if (accept) sum <= sum + data_q;
`endif
    end
  end
endmodule

// File: tb/tb_rt_read_gather.sv
// tb_rt_read_gather: randomized self-checking bench for rt_read_gather.
// Expected quadlets come from a schedule list built from the block layout.
module tb_rt_read_gather;
  localparam int M = 4;
  localparam int E = 4;
  localparam int N = 4 + 2 * M + 5 * E;
`ifdef RT_READ_CHECKSUM_EN
  localparam int NQ = N + 1;
`else
  localparam int NQ = N;
`endif

  logic        sysclk = 1'b0;
  logic        reset, start, rd_gnt, out_ready;
  logic [31:0] timestamp, reg_rdata;
  logic        rd_req, out_valid, out_last, busy;
  logic [15:0] reg_raddr;
  logic [31:0] out_data;
  logic [7:0]  out_index;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] salt;
  logic        bus_ones;
  logic [31:0] got_data[$];
  logic [7:0]  got_idx[$];
  logic        got_last[$];
  logic [31:0] exp_data[$];

  rt_read_gather #(.NUM_MOTORS(M), .NUM_ENCODERS(E)) dut (
    .sysclk(sysclk), .reset(reset), .start(start), .timestamp(timestamp),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .reg_raddr(reg_raddr),
    .reg_rdata(reg_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [31:0] bus_val(input logic [15:0] a);
    return bus_ones ? 32'd1 : ({16'h0, a} ^ salt);
  endfunction

  // Board read bus: data one cycle after the address.
  always @(posedge sysclk) reg_rdata <= bus_val(reg_raddr);

  function automatic void build_model(input logic [31:0] ts);
    logic [15:0] a[$];
    logic [31:0] s;
    a = {};
    a.push_back(16'h0000);
    a.push_back(16'h0000);
    a.push_back(16'h000A);
    a.push_back(16'h000B);
    for (int c = 1; c <= M; c++) a.push_back(16'(c * 16));
    for (int c = 1; c <= M; c++) a.push_back(16'(c * 16 + 12));
    for (int g = 0; g < 5; g++)
      for (int c = 1; c <= E; c++) a.push_back(16'(c * 16 + 5 + g));
    exp_data = {};
    s = 32'h0;
    foreach (a[i]) begin
      exp_data.push_back(i == 1 ? ts : bus_val(a[i]));
      s = s + exp_data[i];
    end
`ifdef RT_READ_CHECKSUM_EN
    exp_data.push_back(32'h0 - s);
`endif
  endfunction

  task automatic tick();
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_idx.push_back(out_index);
      got_last.push_back(out_last);
    end
    @(negedge sysclk);
  endtask

  task automatic kick(input logic [31:0] ts);
    got_data = {};
    got_idx = {};
    got_last = {};
    timestamp = ts;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int gp, input int rp, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      rd_gnt = ($urandom_range(99) < gp);
      out_ready = ($urandom_range(99) < rp);
      if (out_valid && out_ready && out_last) ok = 1'b1;
      tick();
    end
    rd_gnt = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    vectors += 3;
    if (rd_req !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl req/busy/valid %b%b%b want 000", rd_req, busy, out_valid);
    end
    if (reg_raddr !== 16'h0 || out_index !== 8'h0) begin
      errors++;
      $display("FAIL reset_addr raddr %h idx %h want 0", reg_raddr, out_index);
    end
    if (out_data !== 32'h0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_data %h last %b want 0", out_data, out_last);
    end
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    salt = 32'h0;
    build_model(32'h12345678);
    kick(32'h12345678);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency got %0d want 4", lat);
    end
    drain(100, 100, ok);
    vectors++;
    if (!ok || got_data.size() != NQ) begin
      errors++;
      $display("FAIL basic_len got %0d want %0d", got_data.size(), NQ);
    end else begin
      vectors += 3;
      if (got_data[1] !== 32'h12345678) begin
        errors++;
        $display("FAIL basic_ts got %h want 12345678", got_data[1]);
      end
      if (got_data[4] !== 32'h10) begin
        errors++;
        $display("FAIL basic_idx4 got %h want 00000010", got_data[4]);
      end
      if (got_data[31] !== 32'h49 || got_last[31] !== (NQ == 32)) begin
        errors++;
        $display("FAIL basic_idx31 got %h/%b want 00000049/%b", got_data[31], got_last[31], NQ == 32);
      end
    end
    foreach (got_data[i]) begin
      vectors++;
      if (i >= NQ || got_data[i] !== exp_data[i] || got_idx[i] !== 8'(i) || got_last[i] !== (i == NQ - 1)) begin
        errors++;
        $display("FAIL basic_q%0d got %h/%0d/%b want %h/%0d/%b", i, got_data[i], got_idx[i], got_last[i], exp_data[i], i, i == NQ - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] hd;
    logic [7:0] hi;
    logic [31:0] ts;
    salt = $urandom;
    ts = $urandom;
    build_model(ts);
    kick(ts);
    for (int k = 0; k < 200 && !(out_valid && out_index == 8'd7); k++) tick();
    out_ready = 1'b0;
    hd = out_data;
    hi = out_index;
    vectors++;
    if (!(out_valid && hi == 8'd7)) begin
      errors++;
      $display("FAIL bp_reach idx %0d want 7", hi);
    end
    repeat (5) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== hd || out_index !== hi) begin
        errors++;
        $display("FAIL bp_hold got %b/%h/%0d want 1/%h/%0d", out_valid, out_data, out_index, hd, hi);
      end
    end
    drain(100, 100, ok);
    vectors++;
    if (!ok || got_data.size() != NQ) begin
      errors++;
      $display("FAIL bp_len got %0d want %0d", got_data.size(), NQ);
    end
    foreach (got_data[i]) begin
      vectors++;
      if (i >= NQ || got_data[i] !== exp_data[i] || got_idx[i] !== 8'(i) || got_last[i] !== (i == NQ - 1)) begin
        errors++;
        $display("FAIL bp_q%0d got %h/%0d/%b want %h/%0d", i, got_data[i], got_idx[i], got_last[i], exp_data[i], i);
      end
    end
  endtask

  task automatic test_gnt_stall();
    bit ok;
    int lat;
    logic [15:0] ra;
    salt = $urandom;
    build_model(32'hCAFE0001);
    rd_gnt = 1'b0;
    kick(32'hCAFE0001);
    ra = reg_raddr;
    for (int j = 0; j < 10; j++) begin
      vectors++;
      if (rd_req !== 1'b1 || reg_raddr !== ra || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_c%0d req/raddr/valid %b/%h/%b want 1/%h/0", j, rd_req, reg_raddr, out_valid, ra);
      end
      tick();
    end
    rd_gnt = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat != 4) begin
      errors++;
      $display("FAIL stall_latency got %0d want 4", lat);
    end
    drain(100, 100, ok);
    vectors++;
    if (!ok || got_data.size() != NQ) begin
      errors++;
      $display("FAIL stall_len got %0d want %0d", got_data.size(), NQ);
    end
    foreach (got_data[i]) begin
      vectors++;
      if (i >= NQ || got_data[i] !== exp_data[i] || got_idx[i] !== 8'(i)) begin
        errors++;
        $display("FAIL stall_q%0d got %h/%0d want %h/%0d", i, got_data[i], got_idx[i], exp_data[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    salt = $urandom;
    build_model(32'h0BADF00D);
    kick(32'h0BADF00D);
    for (int k = 0; k < 200 && !(out_valid && out_index == 8'd12); k++) tick();
    out_ready = 1'b0;
    vectors++;
    if (!(out_valid && out_index == 8'd12)) begin
      errors++;
      $display("FAIL rmid_reach idx %0d want 12", out_index);
    end
    #3 reset = 1'b1;
    #1;
    vectors++;
    if ({rd_req, busy, out_valid, out_last} !== 4'b0 || reg_raddr !== 16'h0 || out_data !== 32'h0 || out_index !== 8'h0) begin
      errors++;
      $display("FAIL rmid_async req%b busy%b v%b l%b ra%h d%h i%0d want all 0", rd_req, busy, out_valid, out_last, reg_raddr, out_data, out_index);
    end
    @(negedge sysclk);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rmid_quiet valid %b busy %b want 0 0", out_valid, busy);
      end
      tick();
    end
    salt = $urandom;
    build_model(32'h00C0FFEE);
    kick(32'h00C0FFEE);
    drain(100, 100, ok);
    vectors++;
    if (!ok || got_data.size() != NQ) begin
      errors++;
      $display("FAIL rmid_len got %0d want %0d", got_data.size(), NQ);
    end
    foreach (got_data[i]) begin
      vectors++;
      if (i >= NQ || got_data[i] !== exp_data[i] || got_idx[i] !== 8'(i)) begin
        errors++;
        $display("FAIL rmid_q%0d got %h/%0d want %h/%0d", i, got_data[i], got_idx[i], exp_data[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit done;
    salt = $urandom;
    build_model(32'h55AA55AA);
    kick(32'h55AA55AA);
    for (int k = 0; k < 200 && !(out_valid && out_index == 8'd3); k++) tick();
    start = 1'b1;
    timestamp = 32'hFFFFFFFF;
    tick();
    start = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (out_valid && out_last) begin
        start = 1'b1;
        done = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    repeat (8) begin
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle busy %b valid %b want 0 0", busy, out_valid);
      end
      tick();
    end
    vectors++;
    if (!done || got_data.size() != NQ) begin
      errors++;
      $display("FAIL b2b_len got %0d want %0d", got_data.size(), NQ);
    end
    foreach (got_data[i]) begin
      vectors++;
      if (i >= NQ || got_data[i] !== exp_data[i] || got_idx[i] !== 8'(i)) begin
        errors++;
        $display("FAIL b2b_q%0d got %h/%0d want %h/%0d", i, got_data[i], got_idx[i], exp_data[i], i);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] ts;
    for (int b = 0; b < 6; b++) begin
      salt = $urandom;
      ts = $urandom;
      build_model(ts);
      kick(ts);
      drain(60, 60, ok);
      vectors++;
      if (!ok || got_data.size() != NQ) begin
        errors++;
        $display("FAIL rand%0d_len got %0d want %0d", b, got_data.size(), NQ);
      end
      foreach (got_data[i]) begin
        vectors++;
        if (i >= NQ || got_data[i] !== exp_data[i] || got_idx[i] !== 8'(i) || got_last[i] !== (i == NQ - 1)) begin
          errors++;
          $display("FAIL rand%0d_q%0d got %h/%0d/%b want %h/%0d", b, i, got_data[i], got_idx[i], got_last[i], exp_data[i], i);
        end
      end
      repeat ($urandom_range(3)) tick();
    end
  endtask

`ifdef RT_READ_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    bus_ones = 1'b1;
    build_model(32'h1);
    kick(32'h1);
    drain(100, 100, ok);
    vectors++;
    if (!ok || got_data.size() != N + 1) begin
      errors++;
      $display("FAIL csum_len got %0d want %0d", got_data.size(), N + 1);
    end else if (got_data[N] !== 32'hFFFFFFE0 || got_last[N] !== 1'b1 || got_idx[N] !== 8'(N)) begin
      errors++;
      $display("FAIL csum_q got %h/%b/%0d want FFFFFFE0/1/%0d", got_data[N], got_last[N], got_idx[N], N);
    end
    bus_ones = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rd_gnt = 1'b1;
    out_ready = 1'b1;
    timestamp = 32'h0;
    salt = 32'h0;
    bus_ones = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gnt_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef RT_READ_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
